// File: rtl/receiver_buffered.sv
// receiver_buffered: 8N1 UART receiver feeding a small FIFO that downstream
// logic drains through a valid/ready handshake.
//
// Handshake: `valid` is high whenever the FIFO holds a byte and `out` then
// shows the oldest byte; the byte is consumed on any rising clk edge where
// valid && ready are both 1. `ready` while valid=0 is ignored.
module receiver_buffered #(
    // Clock cycles per UART bit (>= 4). The default only lets the module
    // elaborate on its own; each link sets its own value.
    parameter int RECEIVER_PERIOD = 16,
    parameter int IN_BUFFER_WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic [7:0] out,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int CW = $clog2(RECEIVER_PERIOD);
    // The counter counts down to zero, so "load N" is stored as N-1; this
    // keeps a power-of-two period inside clog2(RECEIVER_PERIOD) bits.
    localparam logic [CW-1:0] FULL_LOAD = CW'(RECEIVER_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(RECEIVER_PERIOD / 2 - 1);
    localparam int DEPTH = 2 ** IN_BUFFER_WIDTH;
    localparam logic [IN_BUFFER_WIDTH-1:0] PTR_ONE = IN_BUFFER_WIDTH'(1);

    state_t                     state;
    logic [CW-1:0]              cnt;
    logic [2:0]                 bit_cnt;
    logic [7:0]                 shreg;
    logic                       rx_meta;
    logic                       rx_s;
    logic                       rx_prev;
    logic [7:0]                 mem [DEPTH];
    logic [IN_BUFFER_WIDTH-1:0] in_ptr;
    logic [IN_BUFFER_WIDTH-1:0] out_ptr;
    logic                       full;
    logic                       push_cand;
    logic                       pop;

    assign dbg_state = state;
    assign full      = (in_ptr + PTR_ONE) == out_ptr;
    assign valid     = in_ptr != out_ptr;
    assign out       = mem[out_ptr];
    assign pop       = valid && ready;
    // A good stop bit sampled this cycle: the shift register holds the byte.
    assign push_cand = (state == STOP) && (cnt == '0) && rx_s;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Frame FSM: mid-bit sampling timed by the down-counting cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            framing_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        cnt   <= HALF_LOAD;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            cnt     <= FULL_LOAD;
                            bit_cnt <= '0;
                            state   <= DATA;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cnt     <= FULL_LOAD;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        // Leave mid stop bit so a back-to-back start edge is seen.
                        state <= IDLE;
                        if (!rx_s) begin
                            framing_error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage write; no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push_cand && !full) begin
            mem[in_ptr] <= shreg;
        end
    end

    // FIFO pointers and overrun flag; full is judged before any same-cycle pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ptr  <= '0;
            out_ptr <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_cand) begin
                if (!full) begin
                    in_ptr <= in_ptr + PTR_ONE;
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (pop) begin
                out_ptr <= out_ptr + PTR_ONE;
            end
        end
    end

endmodule
